// File: rtl/cp_pkg.sv
// Shared constants and types for the cyclic-prefix insertion block.
package cp_pkg;

  localparam int N_FFT = 256;
  localparam int N_CP  = 64;
  localparam int DW    = 16;
  localparam int IDX_W = $clog2(N_FFT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CP,
    ST_BODY
  } cp_state_t;

  typedef logic             bank_t;
  typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/cp_bank_ram.sv
// Two-bank sample store: one write port, one read port, registered read data.
// The bank select is the address MSB.
module cp_bank_ram #(
  parameter int AW = 9,
  parameter int W  = 32
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [0:(2**AW)-1];
  logic [W-1:0] rd_data_q;

  // Write port and one-cycle registered read port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/cp_insert.sv
// Cyclic-prefix insertion: buffers each input symbol in a ping-pong bank and
// replays its tail (the prefix) followed by the whole symbol, contiguously.
module cp_insert
  import cp_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] x_real,
  input  logic [DW-1:0] x_img,
  output logic          out_valid,
  output logic [DW-1:0] y_real,
  output logic [DW-1:0] y_img,
  output logic          out_sof,
  output logic          overflow
);

  cp_state_t state_q, state_d;
  idx_t      in_cnt_q, in_cnt_d;
  idx_t      rd_cnt_q, rd_cnt_d;
  bank_t     wr_bank_q, wr_bank_d;
  bank_t     rd_bank_q, rd_bank_d;
  logic      drop_q, drop_d;
  logic [1:0] pending_q, pending_d;
  logic      overflow_q, overflow_d;
  logic      out_valid_q, out_valid_d;
  logic      out_sof_q, out_sof_d;

  logic       reading, free0, free1, no_free, first_smp, last_smp, cur_drop;
  bank_t      alloc_bank, cur_bank, next_bank;
  logic       wr_en, rd_en;
  logic [1:0] set_vec, clr_vec, avail;
  idx_t       rd_idx;
  logic [2*DW-1:0] rd_data;

  // Input side: bank allocation at the first sample, write addressing, drop tracking.
  always_comb begin
    reading    = (state_q != ST_IDLE);
    free0      = !pending_q[0] && !(reading && (rd_bank_q == 1'b0));
    free1      = !pending_q[1] && !(reading && (rd_bank_q == 1'b1));
    no_free    = !free0 && !free1;
    alloc_bank = free0 ? 1'b0 : 1'b1;
    first_smp  = in_valid && (in_cnt_q == '0);
    last_smp   = in_valid && (in_cnt_q == idx_t'(N_FFT - 1));
    cur_bank   = (in_cnt_q == '0) ? alloc_bank : wr_bank_q;
    cur_drop   = (in_cnt_q == '0) ? no_free : drop_q;
    wr_en      = in_valid && !cur_drop;
    set_vec    = 2'b00;
    if (last_smp && !cur_drop) begin
      set_vec[cur_bank] = 1'b1;
    end
    in_cnt_d = in_cnt_q;
    if (in_valid) begin
      in_cnt_d = last_smp ? '0 : in_cnt_q + 1'b1;
    end
    wr_bank_d  = first_smp ? alloc_bank : wr_bank_q;
    drop_d     = first_smp ? no_free : drop_q;
    overflow_d = overflow_q | (first_smp && no_free);
  end

  // Output FSM: picks a completed bank, reads prefix then body, chains banks without gaps.
  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    clr_vec   = 2'b00;
    rd_en     = 1'b0;
    rd_idx    = '0;
    out_sof_d = 1'b0;
    next_bank = ~rd_bank_q;
    avail     = pending_q | set_vec;
    case (state_q)
      ST_IDLE: begin
        if (avail != 2'b00) begin
          state_d  = ST_CP;
          rd_cnt_d = '0;
          if (avail[0]) begin
            rd_bank_d  = 1'b0;
            clr_vec[0] = 1'b1;
          end else begin
            rd_bank_d  = 1'b1;
            clr_vec[1] = 1'b1;
          end
        end
      end
      ST_CP: begin
        rd_en     = 1'b1;
        rd_idx    = idx_t'(N_FFT - N_CP) + rd_cnt_q;
        out_sof_d = (rd_cnt_q == '0);
        if (rd_cnt_q == idx_t'(N_CP - 1)) begin
          state_d  = ST_BODY;
          rd_cnt_d = '0;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      ST_BODY: begin
        rd_en  = 1'b1;
        rd_idx = rd_cnt_q;
        if (rd_cnt_q == idx_t'(N_FFT - 1)) begin
          rd_cnt_d = '0;
          if (avail[next_bank]) begin
            state_d            = ST_CP;
            rd_bank_d          = next_bank;
            clr_vec[next_bank] = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    pending_d   = (pending_q | set_vec) & ~clr_vec;
    out_valid_d = rd_en;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      in_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      drop_q      <= 1'b0;
      pending_q   <= 2'b00;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      drop_q      <= drop_d;
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
    end
  end

  cp_bank_ram #(
    .AW(IDX_W + 1),
    .W (2 * DW)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr({cur_bank, in_cnt_q}),
    .wr_data({x_real, x_img}),
    .rd_en  (rd_en),
    .rd_addr({rd_bank_q, rd_idx}),
    .rd_data(rd_data)
  );

  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign overflow  = overflow_q;
  assign y_real    = out_valid_q ? rd_data[2*DW-1:DW] : '0;
  assign y_img     = out_valid_q ? rd_data[DW-1:0]    : '0;

endmodule

// File: tb/tb_cp_insert.sv
// Directed bench for cp_insert: latency, prefix/body ordering, ping-pong
// chaining, overflow drop and reset behaviour.
module tb_cp_insert;
  import cp_pkg::*;

  localparam int SYM_OUT = N_FFT + N_CP;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] x_real = '0;
  logic [DW-1:0] x_img = '0;
  logic          out_valid;
  logic [DW-1:0] y_real;
  logic [DW-1:0] y_img;
  logic          out_sof;
  logic          overflow;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int glitch = 0;
  int last_in_cyc = 0;
  int o_re[$];
  int o_im[$];
  int o_sof[$];
  int o_cyc[$];

  cp_insert dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .x_real   (x_real),
    .x_img    (x_img),
    .out_valid(out_valid),
    .y_real   (y_real),
    .y_img    (y_img),
    .out_sof  (out_sof),
    .overflow (overflow)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every valid output sample; count non-zero outputs while idle.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      o_re.push_back(int'($signed(y_real)));
      o_im.push_back(int'($signed(y_img)));
      o_sof.push_back(int'(out_sof));
      o_cyc.push_back(cyc);
    end else if (out_valid === 1'b0 &&
                 (y_real !== '0 || y_img !== '0 || out_sof !== 1'b0)) begin
      glitch = glitch + 1;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic clear_log();
    o_re.delete();
    o_im.delete();
    o_sof.delete();
    o_cyc.delete();
    glitch = 0;
  endtask

  task automatic do_idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      x_real   = '0;
      x_img    = '0;
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_log();
  endtask

  task automatic send_symbol(input int base, input int n, input bit toggle);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_valid    = 1'b1;
      x_real      = DW'(base + i);
      x_img       = DW'(-(base + i));
      last_in_cyc = cyc;
      if (toggle && i < n - 1) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic wait_out(input int n, input int budget, input int settle);
    int k;
    k = 0;
    do_idle(1);
    while (o_re.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    repeat (settle) @(posedge clk);
  endtask

  task automatic check_count(input string name, input int expected);
    n_cmp++;
    if (o_re.size() !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s count: got %0d samples, required %0d", name, o_re.size(), expected);
    end
  endtask

  task automatic check_sym(input string name, input int start, input int base);
    int idx;
    int er;
    int es;
    for (int k = 0; k < SYM_OUT; k++) begin
      idx = start + k;
      er  = base + ((k < N_CP) ? (N_FFT - N_CP + k) : (k - N_CP));
      es  = (k == 0) ? 1 : 0;
      n_cmp++;
      if (idx >= o_re.size()) begin
        n_bad++;
        $display("[TB] FAIL %s sample %0d: missing, required re=%0d", name, k, er);
      end else if (o_re[idx] !== er || o_im[idx] !== -er || o_sof[idx] !== es) begin
        n_bad++;
        $display("[TB] FAIL %s sample %0d: got re=%0d im=%0d sof=%0d, required re=%0d im=%0d sof=%0d",
                 name, k, o_re[idx], o_im[idx], o_sof[idx], er, -er, es);
      end
    end
  endtask

  task automatic check_contig(input string name, input int n);
    int brk;
    brk = -1;
    for (int k = 1; k < n && k < o_cyc.size(); k++) begin
      if (brk < 0 && o_cyc[k] != o_cyc[0] + k) brk = k;
    end
    n_cmp++;
    if (brk !== -1) begin
      n_bad++;
      $display("[TB] FAIL %s contiguity: gap before sample %0d, required none", name, brk);
    end
  endtask

  task automatic check_latency(input string name);
    n_cmp++;
    if (o_cyc.size() == 0) begin
      n_bad++;
      $display("[TB] FAIL %s latency: no output, required at cycle %0d", name, last_in_cyc + 2);
    end else if (o_cyc[0] !== last_in_cyc + 2) begin
      n_bad++;
      $display("[TB] FAIL %s latency: first output at %0d, required %0d", name, o_cyc[0], last_in_cyc + 2);
    end
  endtask

  task automatic check_flags(input string name, input logic exp_ovf);
    n_cmp++;
    if (overflow !== exp_ovf) begin
      n_bad++;
      $display("[TB] FAIL %s overflow: got %b, required %b", name, overflow, exp_ovf);
    end
    n_cmp++;
    if (glitch !== 0) begin
      n_bad++;
      $display("[TB] FAIL %s idle outputs: %0d non-zero idle samples, required 0", name, glitch);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || out_sof !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL reset valid/sof: got %b/%b, required 0/0", out_valid, out_sof);
    end
    n_cmp++;
    if (y_real !== '0 || y_img !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset data: got %h/%h, required 0/0", y_real, y_img);
    end
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL reset overflow: got %b, required 0", overflow);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_log();
    do_idle(20);
    check_count("reset_quiet", 0);
  endtask

  task automatic test_single();
    send_symbol(0, N_FFT, 1'b0);
    wait_out(SYM_OUT, 1000, 40);
    check_count("single", SYM_OUT);
    check_latency("single");
    check_contig("single", SYM_OUT);
    check_sym("single", 0, 0);
    check_flags("single", 1'b0);
  endtask

  task automatic test_two_gap();
    do_reset(2);
    send_symbol(0, N_FFT, 1'b0);
    do_idle(N_CP);
    send_symbol(1000, N_FFT, 1'b0);
    wait_out(2 * SYM_OUT, 2000, 40);
    check_count("two_gap", 2 * SYM_OUT);
    check_contig("two_gap", 2 * SYM_OUT);
    check_sym("two_gap_s0", 0, 0);
    check_sym("two_gap_s1", SYM_OUT, 1000);
    check_flags("two_gap", 1'b0);
  endtask

  task automatic test_back_to_back();
    do_reset(2);
    send_symbol(0, N_FFT, 1'b0);
    send_symbol(1000, N_FFT, 1'b0);
    send_symbol(2000, N_FFT, 1'b0);
    wait_out(2 * SYM_OUT, 2000, 400);
    check_count("b2b", 2 * SYM_OUT);
    check_contig("b2b", 2 * SYM_OUT);
    check_sym("b2b_s0", 0, 0);
    check_sym("b2b_s1", SYM_OUT, 1000);
    check_flags("b2b", 1'b1);
  endtask

  task automatic test_toggle();
    do_reset(2);
    @(negedge clk);
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL toggle overflow after reset: got %b, required 0", overflow);
    end
    send_symbol(0, N_FFT, 1'b1);
    wait_out(SYM_OUT, 1000, 40);
    check_count("toggle", SYM_OUT);
    check_latency("toggle");
    check_contig("toggle", SYM_OUT);
    check_sym("toggle", 0, 0);
    check_flags("toggle", 1'b0);
  endtask

  task automatic test_reset_mid_input();
    do_reset(2);
    send_symbol(3000, 100, 1'b0);
    do_reset(1);
    send_symbol(0, N_FFT, 1'b0);
    wait_out(SYM_OUT, 1000, 60);
    check_count("rst_in", SYM_OUT);
    check_latency("rst_in");
    check_sym("rst_in", 0, 0);
    check_flags("rst_in", 1'b0);
  endtask

  task automatic test_reset_body();
    int k;
    do_reset(2);
    send_symbol(0, N_FFT, 1'b0);
    do_idle(1);
    k = 0;
    while (o_re.size() < 100 && k < 1000) begin
      @(posedge clk);
      k++;
    end
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || y_real !== '0 || y_img !== '0) begin
      n_bad++;
      $display("[TB] FAIL rst_body next cycle: got valid=%b y=%h/%h, required 0/0/0", out_valid, y_real, y_img);
    end
    clear_log();
    do_idle(400);
    check_count("rst_body_quiet", 0);
    send_symbol(4000, N_FFT, 1'b0);
    wait_out(SYM_OUT, 1000, 40);
    check_count("rst_body_new", SYM_OUT);
    check_sym("rst_body_new", 0, 4000);
    check_flags("rst_body_new", 1'b0);
  endtask

  // Test sequence.
  initial begin
    test_reset();
    test_single();
    test_two_gap();
    test_back_to_back();
    test_toggle();
    test_reset_mid_input();
    test_reset_body();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
